// File: rtl/txpippm_pulse_sequencer.sv
// Command stage for the TX phase-interpolator PPM controllers: accepts one stepping
// command and emits a metered train of single-cycle pulses on the selected channels.
module txpippm_pulse_sequencer #(
  parameter int CHANNEL_COUNT = 10,
  parameter int PERIOD_WIDTH  = 16,
  parameter int COUNT_WIDTH   = 16
) (
  input  logic                     gtwiz_userclk_tx_usrclk_in,
  input  logic                     gtwiz_reset_all_in,
  input  logic                     gtwiz_userclk_tx_active_in,
  input  logic                     cmd_valid_in,
  output logic                     cmd_ready_out,
  input  logic [CHANNEL_COUNT-1:0] cmd_mask_in,
  input  logic [PERIOD_WIDTH-1:0]  cmd_period_in,
  input  logic [COUNT_WIDTH-1:0]   cmd_count_in,
  input  logic [4:0]               cmd_stepsize_in,
  input  logic                     abort_in,
  output logic [CHANNEL_COUNT-1:0] sel_out,
  output logic                     pulse_out,
  output logic [4:0]               stepsize_out,
  output logic                     busy_out,
  output logic                     done_out,
  output logic [COUNT_WIDTH-1:0]   pulses_sent_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                   state_q, state_d;
  logic [PERIOD_WIDTH-1:0]  period_q, period_d;
  logic [PERIOD_WIDTH-1:0]  cnt_q, cnt_d;
  logic [COUNT_WIDTH-1:0]   count_q, count_d;
  logic [COUNT_WIDTH-1:0]   sent_q, sent_d;
  logic [CHANNEL_COUNT-1:0] sel_q, sel_d;
  logic [4:0]               step_q, step_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;

  logic                     accept;
  logic                     pulse_due;
  logic [PERIOD_WIDTH-1:0]  peff_m1;
  logic [COUNT_WIDTH-1:0]   sent_inc;

  // Handshake: a command is taken on any edge where cmd_valid_in & cmd_ready_out.
  // cmd_ready_out depends only on state, clock-active and reset, never on cmd_valid_in.
  assign cmd_ready_out = (state_q == S_IDLE) & gtwiz_userclk_tx_active_in & ~gtwiz_reset_all_in;
  assign accept        = cmd_valid_in & cmd_ready_out;

  // Pulse is decoded in the cycle the counter expires so abort can veto it same-cycle.
  assign pulse_due = (state_q == S_RUN) & gtwiz_userclk_tx_active_in & ~abort_in &
                     (cnt_q == '0) & ~gtwiz_reset_all_in;

  // Periods below 2 are clamped so the pulse always returns low between pulses.
  assign peff_m1  = (cmd_period_in < PERIOD_WIDTH'(2)) ? PERIOD_WIDTH'(1)
                                                       : cmd_period_in - PERIOD_WIDTH'(1);
  assign sent_inc = (&sent_q) ? sent_q : sent_q + COUNT_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cnt_d    = cnt_q;
    count_d  = count_q;
    sent_d   = sent_q;
    sel_d    = sel_q;
    step_d   = step_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          period_d = peff_m1;
          cnt_d    = peff_m1;
          count_d  = cmd_count_in;
          step_d   = cmd_stepsize_in;
          sent_d   = '0;
          if (cmd_mask_in == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            sel_d   = '0;
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
            sel_d   = cmd_mask_in;
          end
        end
      end

      S_RUN: begin
        if (abort_in) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          sel_d   = '0;
        end else if (gtwiz_userclk_tx_active_in) begin
          if (cnt_q == '0) begin
            cnt_d  = period_q;
            sent_d = sent_inc;
            if ((count_q != '0) && (sent_inc == count_q)) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
              sel_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - PERIOD_WIDTH'(1);
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        sel_d   = '0;
      end
    endcase
  end

  always_ff @(posedge gtwiz_userclk_tx_usrclk_in) begin
    if (gtwiz_reset_all_in) begin
      state_q  <= S_IDLE;
      period_q <= '0;
      cnt_q    <= '0;
      count_q  <= '0;
      sent_q   <= '0;
      sel_q    <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      sent_q   <= sent_d;
      sel_q    <= sel_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign sel_out         = sel_q;
  assign pulse_out       = pulse_due;
  assign stepsize_out    = step_q;
  assign busy_out        = busy_q;
  assign done_out        = done_q;
  assign pulses_sent_out = sent_q;

endmodule

// File: tb/tb_txpippm_pulse_sequencer.sv
// Directed bench for txpippm_pulse_sequencer: pulse cycle numbers are relative to the
// accept edge T (first sampled cycle after T is cycle 1).
module tb_txpippm_pulse_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        active;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_mask;
  logic [15:0] cmd_period;
  logic [15:0] cmd_count;
  logic [4:0]  cmd_step;
  logic        abort;
  logic [9:0]  sel;
  logic        pulse;
  logic [4:0]  step;
  logic        busy;
  logic        done;
  logic [15:0] sent;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          done_n;
  int          done_first;
  logic [9:0]  sel_log   [64];
  logic [4:0]  step_log  [64];
  logic [15:0] sent_log  [64];
  logic        busy_log  [64];
  logic        ready_log [64];

  txpippm_pulse_sequencer dut (
    .gtwiz_userclk_tx_usrclk_in (clk),
    .gtwiz_reset_all_in         (rst),
    .gtwiz_userclk_tx_active_in (active),
    .cmd_valid_in               (cmd_valid),
    .cmd_ready_out              (cmd_ready),
    .cmd_mask_in                (cmd_mask),
    .cmd_period_in              (cmd_period),
    .cmd_count_in               (cmd_count),
    .cmd_stepsize_in            (cmd_step),
    .abort_in                   (abort),
    .sel_out                    (sel),
    .pulse_out                  (pulse),
    .stepsize_out               (step),
    .busy_out                   (busy),
    .done_out                   (done),
    .pulses_sent_out            (sent)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Compare observed pulse cycles against the expected queue.
  task automatic check_pulses(input string tag);
    check({tag, "_npulses"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0)
      check({tag, "_pulse_cycle"}, got_q.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_q.delete();
  endtask

  // Called just after a posedge with the DUT idle; returns just after the accept edge.
  task automatic send_cmd(input logic [9:0] m, input logic [15:0] p, input logic [15:0] c,
                          input logic [4:0] s);
    cmd_mask   = m;
    cmd_period = p;
    cmd_count  = c;
    cmd_step   = s;
    cmd_valid  = 1'b1;
    @(negedge clk);
    check("ready_before_accept", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid  = 1'b0;
    cmd_mask   = 10'($urandom_range(0, 1023));
    cmd_period = 16'($urandom_range(0, 65535));
    cmd_count  = 16'($urandom_range(0, 65535));
    cmd_step   = 5'($urandom_range(0, 31));
  endtask

  // Runs n cycles, logging outputs; optional abort / freeze window / reset cycle.
  task automatic observe(input int n, input int abort_at, input int frz_start,
                         input int frz_len, input int rst_at);
    got_q.delete();
    done_n     = 0;
    done_first = 0;
    for (int j = 1; j <= n; j++) begin
      abort  = (j == abort_at);
      active = !(frz_len > 0 && j >= frz_start && j < frz_start + frz_len);
      rst    = (j == rst_at);
      @(negedge clk);
      sel_log[j]   = sel;
      step_log[j]  = step;
      sent_log[j]  = sent;
      busy_log[j]  = busy;
      ready_log[j] = cmd_ready;
      if (pulse) got_q.push_back(j);
      if (done) begin
        done_n++;
        if (done_n == 1) done_first = j;
      end
      @(posedge clk);
      #1;
    end
    abort  = 1'b0;
    active = 1'b1;
    rst    = 1'b0;
  endtask

  initial begin
    // reset with a command pending
    rst        = 1'b1;
    active     = 1'b1;
    abort      = 1'b0;
    cmd_valid  = 1'b1;
    cmd_mask   = 10'h3ff;
    cmd_period = 16'd4;
    cmd_count  = 16'd3;
    cmd_step   = 5'd9;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_ready", cmd_ready, 1'b0);
      check("rst_outputs", {sel, pulse, step, busy, done, sent}, '0);
      @(posedge clk);
      #1;
    end
    rst       = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1'b1);
    check("post_rst_busy", busy, 1'b0);
    @(posedge clk);
    #1;

    // basic run: mask 5, period 4, count 3, step 7
    send_cmd(10'b0000000101, 16'd4, 16'd3, 5'd7);
    observe(16, 0, 0, 0, 0);
    exp_q.push_back(4); exp_q.push_back(8); exp_q.push_back(12);
    check_pulses("basic");
    check("basic_done_cycle", done_first, 13);
    check("basic_done_n", done_n, 1);
    check("basic_sel_run", sel_log[1], 10'b0000000101);
    check("basic_busy_run", busy_log[1], 1'b1);
    check("basic_step", step_log[1], 5'd7);
    check("basic_sent_mid", sent_log[12], 16'd2);
    check("basic_sent_end", sent_log[13], 16'd3);
    check("basic_sel_done", sel_log[13], 10'd0);
    check("basic_busy_done", busy_log[13], 1'b0);
    check("basic_ready_done", ready_log[13], 1'b0);
    check("basic_ready_after", ready_log[14], 1'b1);
    check("basic_step_held", step_log[16], 5'd7);
    check("basic_sent_held", sent_log[16], 16'd3);

    // period 0 clamps to 2
    send_cmd(10'h3ff, 16'd0, 16'd2, 5'd1);
    observe(8, 0, 0, 0, 0);
    exp_q.push_back(2); exp_q.push_back(4);
    check_pulses("clamp");
    check("clamp_done_cycle", done_first, 5);
    check("clamp_sent", sent_log[8], 16'd2);

    // empty mask completes at once
    send_cmd(10'd0, 16'd9, 16'd4, 5'd3);
    observe(6, 0, 0, 0, 0);
    check_pulses("empty");
    check("empty_done_cycle", done_first, 1);
    check("empty_done_n", done_n, 1);
    check("empty_busy", busy_log[1], 1'b0);
    check("empty_sent", sent_log[1], 16'd0);
    check("empty_step", step_log[1], 5'd3);

    // continuous run, abort on a cycle where a pulse is due
    send_cmd(10'b1000000001, 16'd5, 16'd0, 5'd2);
    observe(24, 20, 0, 0, 0);
    exp_q.push_back(5); exp_q.push_back(10); exp_q.push_back(15);
    check_pulses("abort");
    check("abort_done_cycle", done_first, 21);
    check("abort_sent", sent_log[21], 16'd3);
    check("abort_sel_done", sel_log[21], 10'd0);

    // clock-inactive for cycles 2..7 stretches spacing by 6
    send_cmd(10'b0000110000, 16'd4, 16'd2, 5'd4);
    observe(18, 0, 2, 6, 0);
    exp_q.push_back(10); exp_q.push_back(14);
    check_pulses("freeze");
    check("freeze_done_cycle", done_first, 15);
    check("freeze_busy", busy_log[5], 1'b1);
    check("freeze_ready", ready_log[5], 1'b0);
    check("freeze_sel", sel_log[5], 10'b0000110000);

    // reset after 1 of 3 pulses, then a fresh command
    send_cmd(10'b0000000010, 16'd3, 16'd3, 5'd5);
    observe(9, 0, 0, 0, 5);
    exp_q.push_back(3);
    check_pulses("midrst");
    check("midrst_done_n", done_n, 0);
    check("midrst_sent_before", sent_log[4], 16'd1);
    check("midrst_outputs", {sel_log[6], step_log[6], sent_log[6], busy_log[6]}, '0);
    check("midrst_ready", ready_log[6], 1'b1);
    send_cmd(10'b0000000010, 16'd2, 16'd1, 5'd6);
    observe(5, 0, 0, 0, 0);
    exp_q.push_back(2);
    check_pulses("fresh");
    check("fresh_done_cycle", done_first, 3);
    check("fresh_sent", sent_log[3], 16'd1);
    check("fresh_step", step_log[1], 5'd6);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/txpippm_pulse_sequencer.md
# txpippm_pulse_sequencer

Upstream command stage for the per-channel TX phase-interpolator PPM controllers. It accepts one stepping command at a time: a channel mask, a pulse period, a pulse count and a step size. It then drives the controllers' shared `pulse`, per-channel `sel` and shared `stepsize` inputs with a metered train of single-cycle pulses, and reports progress and completion. It runs entirely in the TXUSRCLK domain.

## Interface
- `CHANNEL_COUNT`, 10, number of channels; width of mask and `sel_out`
- `PERIOD_WIDTH`, 16, width of the pulse-period field
- `COUNT_WIDTH`, 16, width of the pulse-count field and the progress counter
- `gtwiz_userclk_tx_usrclk_in`  in  1  clock (TXUSRCLK)
- `gtwiz_reset_all_in`  in  1  reset; synchronous, active-high; already synchronised to TXUSRCLK by the instantiating logic
- `gtwiz_userclk_tx_active_in`  in  1  user clock valid; low freezes the sequencer
- `cmd_valid_in`  in  1  command valid
- `cmd_ready_out`  out  1  command ready
- `cmd_mask_in`  in  CHANNEL_COUNT  channels to step
- `cmd_period_in`  in  PERIOD_WIDTH  cycles between pulses
- `cmd_count_in`  in  COUNT_WIDTH  pulses to issue; 0 means continuous
- `cmd_stepsize_in`  in  5  step size forwarded to the controllers
- `abort_in`  in  1  stop the current run
- `sel_out`  out  CHANNEL_COUNT  channel select to the controllers
- `pulse_out`  out  1  one-cycle step pulse to the controllers
- `stepsize_out`  out  5  step size to the controllers
- `busy_out`  out  1  run in progress
- `done_out`  out  1  one-cycle completion strobe
- `pulses_sent_out`  out  COUNT_WIDTH  pulses issued in the current or last run

## Operation
- States:
  - IDLE
  - RUN
  - DONE, which lasts exactly one cycle and then returns to IDLE
- Reset:
  - state goes to IDLE
  - every registered output is 0: `sel_out`, `pulse_out`, `stepsize_out`, `busy_out`, `done_out`, `pulses_sent_out`
  - all internal counters are 0
- `cmd_ready_out` is combinational: (state==IDLE) & `gtwiz_userclk_tx_active_in` & ~`gtwiz_reset_all_in`.
- Accept: a command is accepted on a clock edge where `cmd_valid_in` & `cmd_ready_out`. On accept the block:
  - latches mask, period, count and stepsize
  - clears `pulses_sent_out`
  - loads the period counter with Peff-1, where Peff = max(`cmd_period_in`, 2); periods 0 and 1 are clamped to 2 so `pulse_out` always returns low between pulses
- Accepting a command with mask == 0 goes straight to DONE and issues no pulses.
- Otherwise the state goes to RUN, with `sel_out` = mask, `stepsize_out` = stepsize and `busy_out` = 1.
- RUN, each cycle with active = 1 and no abort:
  - if the period counter is 0: `pulse_out` = 1, the counter reloads Peff-1, `pulses_sent_out` increments
  - otherwise the counter decrements
- `pulses_sent_out` saturates at all-ones; it never wraps.
- When count ≠ 0, the state goes to DONE on the cycle after the pulse that makes `pulses_sent_out` equal count.
- When count == 0, RUN continues until abort.
- RUN with active = 0:
  - the period counter holds and no pulse is issued
  - `sel_out` and `busy_out` hold
  - abort is still honoured
- `abort_in` in RUN goes to DONE immediately. Abort wins over a due pulse in the same cycle, so no pulse is issued. `abort_in` outside RUN is ignored.
- DONE cycle: `done_out` = 1, `busy_out` = 0, `sel_out` = 0.
- Held values after a run: `stepsize_out` and `pulses_sent_out` hold their last values until the next accept.
- Reset mid-run: on the next edge the block returns to IDLE with all reset values, and no `done_out` is issued.

## Timing
- Accept at edge T: `sel_out`, `stepsize_out` and `busy_out` become valid after T (cycle T+1).
- The first pulse is in cycle T+Peff; later pulses follow every Peff cycles, counting only cycles with active = 1.
- The final (count-th) pulse is in cycle T+count·Peff, with `done_out` in the following cycle. `cmd_ready_out` rises in the cycle after `done_out`, so a new accept is possible at the earliest 2 cycles after the final pulse.
- `pulses_sent_out` shows the new value in the cycle after each pulse.
- Abort asserted in cycle A (in RUN) gives `done_out` in cycle A+1, with no pulse in cycle A.
- `pulse_out` is high for exactly one cycle per pulse.

## Test plan
- Reset:
  - stimulus: assert reset for 3 cycles with `cmd_valid_in` = 1
  - required response: all outputs 0, no accept, `cmd_ready_out` = 0 during reset and 1 in the first cycle after reset
- Basic run:
  - stimulus: mask = 10'b0000000101, period = 4, count = 3, stepsize = 7, accepted at T
  - required response: `pulse_out` high at T+4, T+8 and T+12; `done_out` at T+13; `pulses_sent_out` = 3; `sel_out` = 0 from T+13; `stepsize_out` = 7
- Clamp and empty mask:
  - stimulus 1: period = 0, count = 2
  - required response 1: pulses at T+2 and T+4
  - stimulus 2: mask = 0
  - required response 2: `done_out` at T+1 with no pulses
- Continuous plus abort:
  - stimulus: count = 0, period = 5; assert abort in a cycle where a pulse is due
  - required response: no pulse in that cycle, `done_out` the next cycle, `pulses_sent_out` equals the number of prior pulses
- Freeze:
  - stimulus: drop `gtwiz_userclk_tx_active_in` for 6 cycles mid-period during a run with period = 4, count = 2
  - required response: pulse spacing stretches by exactly 6 cycles, `busy_out` stays 1, `cmd_ready_out` = 0
- Reset mid-run:
  - stimulus: assert reset after 1 of 3 pulses
  - required response: IDLE with all outputs 0, no `done_out`; a fresh command then runs normally
